// File: rtl/kamikaze_prefetch_pkg.sv
// Shared AHB-Lite encodings and the prefetch FIFO entry layout.
package kamikaze_defs;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_OPCODE  = 4'b0000;

  // One buffered fetch: error flag, word address, instruction word.
  localparam int ENTRY_W = 65;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/kamikaze_sync_fifo.sv
// Small synchronous FIFO with flush; head word is read straight from storage.
module kamikaze_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop;

  // Pointer and occupancy update; flush wins over push and pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_i, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/kamikaze_prefetch.sv
// AHB-Lite instruction prefetcher: issues single-word reads ahead of fetch,
// buffers results with their addresses, handles waits, flush and bus errors.
module kamikaze_prefetch
  import kamikaze_defs::*;
#(
  parameter int DEPTH   = 4,
  parameter int FIFO_AW = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic        pf_flush_i,
  input  logic [31:0] pf_flush_addr_i,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic        HMASTLOCK,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        pf_valid_o,
  output logic [31:0] pf_data_o,
  output logic [31:0] pf_addr_o,
  output logic        pf_err_o,
  input  logic        pf_ready_i
);

  htrans_e           htrans_q, htrans_d;
  logic [31:0]       haddr_q, haddr_d;
  logic [31:0]       next_addr_q, next_addr_d;
  logic [31:0]       dp_addr_q, dp_addr_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_discard_q, dp_discard_d;
  logic              stale_q, stale_d;     // held NONSEQ predates a flush
  logic              halted_q, halted_d;

  logic              accept, complete, err_wait;
  logic              fifo_push, fifo_pop, can_issue;
  entry_t            push_entry, head_entry;
  logic [FIFO_AW:0]  fifo_count, count_after;
  logic [FIFO_AW+1:0] credit_used;
  logic              unused_bits;

  kamikaze_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .flush_i (pf_flush_i),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_entry),
    .count_o (fifo_count)
  );

  // Bus events of this cycle and the FIFO handshake they imply.
  always_comb begin
    accept     = (htrans_q == HTRANS_NONSEQ) && HREADY;
    complete   = dp_valid_q && HREADY;
    err_wait   = dp_valid_q && HRESP && !HREADY;
    fifo_push  = complete && !dp_discard_q && !pf_flush_i;
    fifo_pop   = pf_valid_o && pf_ready_i && !pf_flush_i;
    push_entry = '{err: HRESP, addr: dp_addr_q, data: (HRESP ? 32'd0 : HRDATA)};
  end

  // Next-state: data phase tracking, fetch pointer, halt, credit and address phase.
  always_comb begin
    htrans_d     = htrans_q;
    haddr_d      = haddr_q;
    next_addr_d  = next_addr_q;
    dp_addr_d    = dp_addr_q;
    dp_valid_d   = dp_valid_q;
    dp_discard_d = dp_discard_q;
    stale_d      = stale_q;
    halted_d     = halted_q;

    if (accept) begin
      dp_valid_d   = 1'b1;
      dp_addr_d    = haddr_q;
      dp_discard_d = stale_q || pf_flush_i;
    end else if (complete) begin
      dp_valid_d   = 1'b0;
      dp_discard_d = 1'b0;
    end else begin
      dp_discard_d = dp_discard_q || (pf_flush_i && dp_valid_q);
    end

    if (pf_flush_i)             next_addr_d = {pf_flush_addr_i[31:2], 2'b00};
    else if (accept && !stale_q) next_addr_d = next_addr_q + 32'd4;

    if (pf_flush_i)                halted_d = 1'b0;
    else if (fifo_push && HRESP)   halted_d = 1'b1;

    // Words buffered after this edge plus the data phase still owed to us.
    count_after = fifo_count;
    if (pf_flush_i)                  count_after = '0;
    else if (fifo_push && !fifo_pop) count_after = fifo_count + (FIFO_AW+1)'(1);
    else if (!fifo_push && fifo_pop) count_after = fifo_count - (FIFO_AW+1)'(1);
    credit_used = {1'b0, count_after} + (FIFO_AW+2)'(dp_valid_d);
    can_issue   = !halted_d && (credit_used < (FIFO_AW+2)'(DEPTH));

    if (err_wait) begin
      htrans_d = HTRANS_IDLE;
      stale_d  = 1'b0;
    end else if ((htrans_q == HTRANS_NONSEQ) && !HREADY) begin
      stale_d  = stale_q || pf_flush_i;
    end else begin
      stale_d  = 1'b0;
      if (can_issue) begin
        htrans_d = HTRANS_NONSEQ;
        haddr_d  = next_addr_d;
      end else begin
        htrans_d = HTRANS_IDLE;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      htrans_q     <= HTRANS_IDLE;
      haddr_q      <= '0;
      next_addr_q  <= {boot_addr_i[31:2], 2'b00};
      dp_addr_q    <= '0;
      dp_valid_q   <= 1'b0;
      dp_discard_q <= 1'b0;
      stale_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      htrans_q     <= htrans_d;
      haddr_q      <= haddr_d;
      next_addr_q  <= next_addr_d;
      dp_addr_q    <= dp_addr_d;
      dp_valid_q   <= dp_valid_d;
      dp_discard_q <= dp_discard_d;
      stale_q      <= stale_d;
      halted_q     <= halted_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_OPCODE;
  assign HWRITE    = 1'b0;
  assign HWDATA    = 32'd0;
  assign HMASTLOCK = 1'b0;

  assign pf_valid_o = (fifo_count != '0);
  assign pf_data_o  = pf_valid_o ? head_entry.data : 32'd0;
  assign pf_addr_o  = pf_valid_o ? head_entry.addr : 32'd0;
  assign pf_err_o   = pf_valid_o && head_entry.err;

  // Byte-offset bits of the address inputs carry no meaning for word fetch.
  assign unused_bits = ^{boot_addr_i[1:0], pf_flush_addr_i[1:0]};

endmodule

// File: tb/tb_kamikaze_prefetch.sv
// Directed bench for kamikaze_prefetch: the bench plays AHB slave and fetch consumer.
module tb_kamikaze_prefetch;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] boot_addr_i;
  logic        pf_flush_i;
  logic [31:0] pf_flush_addr_i;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        pf_valid_o;
  logic [31:0] pf_data_o;
  logic [31:0] pf_addr_o;
  logic        pf_err_o;
  logic        pf_ready_i;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  always #5 clk = ~clk;

  kamikaze_prefetch #(.DEPTH(4), .FIFO_AW(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .boot_addr_i     (boot_addr_i),
    .pf_flush_i      (pf_flush_i),
    .pf_flush_addr_i (pf_flush_addr_i),
    .HADDR           (HADDR),
    .HTRANS          (HTRANS),
    .HSIZE           (HSIZE),
    .HBURST          (HBURST),
    .HPROT           (HPROT),
    .HWRITE          (HWRITE),
    .HWDATA          (HWDATA),
    .HMASTLOCK       (HMASTLOCK),
    .HRDATA          (HRDATA),
    .HREADY          (HREADY),
    .HRESP           (HRESP),
    .pf_valid_o      (pf_valid_o),
    .pf_data_o       (pf_data_o),
    .pf_addr_o       (pf_addr_o),
    .pf_err_o        (pf_err_o),
    .pf_ready_i      (pf_ready_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: note whether an address is accepted at the edge, then serve its data.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    acc      = (HTRANS == 2'b10) && HREADY;
    acc_addr = HADDR;
    @(posedge clk);
    #1;
    if (acc) begin
      HRDATA = mem_word(acc_addr);
      n_acc++;
    end
  endtask

  task automatic do_reset(input logic ready);
    rst_i      = 1'b0;
    HREADY     = 1'b1;
    HRESP      = 1'b0;
    pf_flush_i = 1'b0;
    pf_ready_i = ready;
    tick();
    tick();
    rst_i = 1'b1;
    n_acc = 0;
  endtask

  initial begin
    rst_i           = 1'b0;
    boot_addr_i     = 32'h0000_1002;
    pf_flush_i      = 1'b0;
    pf_flush_addr_i = 32'd0;
    HRDATA          = 32'd0;
    HREADY          = 1'b1;
    HRESP           = 1'b0;
    pf_ready_i      = 1'b1;

    // 1: streaming with zero waits
    do_reset(1'b1);
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_valid", 32'(pf_valid_o), 32'h0);
    check("rst_data", pf_data_o, 32'h0);
    check("rst_addr", pf_addr_o, 32'h0);
    check("rst_err", 32'(pf_err_o), 32'h0);
    check("const_hsize", 32'(HSIZE), 32'h2);
    tick();
    check("t1_e0_htrans", 32'(HTRANS), 32'h2);
    check("t1_e0_haddr", HADDR, 32'h1000);
    check("t1_e0_valid", 32'(pf_valid_o), 32'h0);
    tick();
    check("t1_e1_haddr", HADDR, 32'h1004);
    check("t1_e1_valid", 32'(pf_valid_o), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_valid", 32'(pf_valid_o), 32'h1);
      check("t1_addr", pf_addr_o, 32'h1000 + 32'(4 * k));
      check("t1_data", pf_data_o, mem_word(32'h1000 + 32'(4 * k)));
      check("t1_haddr", HADDR, 32'h1008 + 32'(4 * k));
    end

    // 2: consumer stalled from reset, credit limit
    do_reset(1'b0);
    for (int k = 0; k < 8; k++) tick();
    check("t2_accepted", 32'(n_acc), 32'd4);
    check("t2_idle", 32'(HTRANS), 32'h0);
    check("t2_head", pf_addr_o, 32'h1000);
    pf_ready_i = 1'b1;
    tick();
    check("t2_reissue_htrans", 32'(HTRANS), 32'h2);
    check("t2_reissue_haddr", HADDR, 32'h1010);
    check("t2_pop0", pf_addr_o, 32'h1004);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t2_valid", 32'(pf_valid_o), 32'h1);
      check("t2_addr", pf_addr_o, 32'h1004 + 32'(4 * k));
      check("t2_data", pf_data_o, mem_word(32'h1004 + 32'(4 * k)));
    end

    // 3: three wait states in the 0x1008 data phase
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) tick();
    check("t3_pre_haddr", HADDR, 32'h100C);
    check("t3_pre_head", pf_addr_o, 32'h1004);
    HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hold_htrans", 32'(HTRANS), 32'h2);
      check("t3_hold_haddr", HADDR, 32'h100C);
    end
    check("t3_drained", 32'(pf_valid_o), 32'h0);
    HREADY = 1'b1;
    tick();
    check("t3_w0_addr", pf_addr_o, 32'h1008);
    check("t3_w0_data", pf_data_o, mem_word(32'h1008));
    check("t3_haddr", HADDR, 32'h1010);
    tick();
    check("t3_w1_addr", pf_addr_o, 32'h100C);
    check("t3_w1_data", pf_data_o, mem_word(32'h100C));
    tick();
    check("t3_w2_addr", pf_addr_o, 32'h1010);

    // 4: flush with two buffered words and a pending data phase
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("t4_pre_head", pf_addr_o, 32'h1000);
    pf_flush_addr_i = 32'h0000_2006;
    pf_flush_i      = 1'b1;
    tick();
    pf_flush_i = 1'b0;
    pf_ready_i = 1'b1;
    check("t4_valid_cleared", 32'(pf_valid_o), 32'h0);
    check("t4_htrans", 32'(HTRANS), 32'h2);
    check("t4_haddr", HADDR, 32'h2004);
    tick();
    check("t4_discard_valid", 32'(pf_valid_o), 32'h0);
    tick();
    check("t4_first_valid", 32'(pf_valid_o), 32'h1);
    check("t4_first_addr", pf_addr_o, 32'h2004);
    check("t4_first_data", pf_data_o, mem_word(32'h2004));
    tick();
    check("t4_second_addr", pf_addr_o, 32'h2008);

    // 5: flush while NONSEQ is held, then an error on the discarded transfer
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) tick();
    HREADY = 1'b0;
    tick();
    pf_flush_addr_i = 32'h0000_3000;
    pf_flush_i      = 1'b1;
    tick();
    pf_flush_i = 1'b0;
    check("t5_held_haddr", HADDR, 32'h100C);
    check("t5_held_htrans", 32'(HTRANS), 32'h2);
    check("t5_valid", 32'(pf_valid_o), 32'h0);
    HREADY = 1'b1;
    tick();
    check("t5_new_haddr", HADDR, 32'h3000);
    check("t5_new_htrans", 32'(HTRANS), 32'h2);
    check("t5_stale_dropped", 32'(pf_valid_o), 32'h0);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick();
    check("t5_err_idle", 32'(HTRANS), 32'h0);
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0;
    check("t5_no_halt_htrans", 32'(HTRANS), 32'h2);
    check("t5_no_halt_haddr", HADDR, 32'h3000);
    check("t5_no_err_entry", 32'(pf_valid_o), 32'h0);
    tick();
    tick();
    check("t5_resume_valid", 32'(pf_valid_o), 32'h1);
    check("t5_resume_addr", pf_addr_o, 32'h3000);
    check("t5_resume_err", 32'(pf_err_o), 32'h0);
    check("t5_resume_data", pf_data_o, mem_word(32'h3000));

    // 6: two-cycle error response on 0x100C
    do_reset(1'b1);
    for (int k = 0; k < 5; k++) tick();
    check("t6_pre_haddr", HADDR, 32'h1010);
    check("t6_pre_head", pf_addr_o, 32'h1008);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick();
    check("t6_err1_idle", 32'(HTRANS), 32'h0);
    check("t6_err1_valid", 32'(pf_valid_o), 32'h0);
    HREADY = 1'b1;
    tick();
    check("t6_entry_valid", 32'(pf_valid_o), 32'h1);
    check("t6_entry_err", 32'(pf_err_o), 32'h1);
    check("t6_entry_addr", pf_addr_o, 32'h100C);
    check("t6_entry_data", pf_data_o, 32'h0);
    check("t6_entry_idle", 32'(HTRANS), 32'h0);
    HRESP      = 1'b0;
    pf_ready_i = 1'b0;
    tick();
    tick();
    check("t6_halted_idle", 32'(HTRANS), 32'h0);
    check("t6_halted_err", 32'(pf_err_o), 32'h1);
    pf_flush_addr_i = 32'h0000_4000;
    pf_flush_i      = 1'b1;
    tick();
    pf_flush_i = 1'b0;
    pf_ready_i = 1'b1;
    check("t6_flush_valid", 32'(pf_valid_o), 32'h0);
    check("t6_flush_htrans", 32'(HTRANS), 32'h2);
    check("t6_flush_haddr", HADDR, 32'h4000);
    tick();
    check("t6_next_haddr", HADDR, 32'h4004);
    tick();
    check("t6_resume_valid", 32'(pf_valid_o), 32'h1);
    check("t6_resume_addr", pf_addr_o, 32'h4000);
    check("t6_resume_err", 32'(pf_err_o), 32'h0);
    check("t6_resume_data", pf_data_o, mem_word(32'h4000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
